// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divider.
package div_pkg;

  localparam int DIV_WIDTH         = 32;
  localparam int DIV_LATENCY       = 34;
  localparam int DIV_EARLY_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         quo_bit
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    quo_bit  = (shifted >= {2'b00, divisor});
    // The difference is below the divisor whenever it is kept, so W+1 bits hold it.
    diff     = shifted[W:0] - {1'b0, divisor};
    rem_next = quo_bit ? diff : shifted[W:0];
  end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative 32-bit signed/unsigned restoring divider returning {remainder, quotient}.
// Optional feature: define DIV_EARLY_OUT_EN to skip iteration for trivial divides.
module mdu_div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               cancel_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  // Handshake: a request is accepted only in IDLE on an edge where start_i=1 and
  // cancel_i=0; the requester holds its stall until the single-cycle ready_o pulse.

  div_state_e         state, state_next;
  logic [4:0]         count;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   dividend_raw;
  logic               neg_quo, neg_rem, div_zero, early_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               accept;
  logic               dividend_neg, divisor_neg;
  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic               early_take;
  logic [WIDTH:0]     rem_next;
  logic               quo_bit;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] fix_result;

  assign accept       = (state == IDLE) && start_i && !cancel_i;
  assign dividend_neg = signed_i & dividend_i[WIDTH-1];
  assign divisor_neg  = signed_i & divisor_i[WIDTH-1];
  assign dividend_mag = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign divisor_mag  = divisor_neg ? (~divisor_i + 1'b1) : divisor_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_take = (divisor_i == '0) || (dividend_mag < divisor_mag);
`else
  assign early_take = 1'b0;
`endif

  div_restore_step #(.W(WIDTH)) u_step (
    .rem          (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (divisor_q),
    .rem_next     (rem_next),
    .quo_bit      (quo_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cancel_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_next = early_take ? FIX : CALC;
        CALC:    if (count == 5'd31) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Divide by zero and early-out report the raw dividend, not its magnitude.
  always_comb begin
    quo_fix = neg_quo ? (~quo_q + 1'b1) : quo_q;
    rem_fix = neg_rem ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    if (div_zero)     fix_result = {dividend_raw, {WIDTH{1'b1}}};
    else if (early_q) fix_result = {dividend_raw, {WIDTH{1'b0}}};
    else              fix_result = {rem_fix, quo_fix};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      divisor_q    <= '0;
      dividend_raw <= '0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      early_q      <= 1'b0;
      result_q     <= '0;
      ready_q      <= 1'b0;
    end else begin
      ready_q <= (state == DONE) && !cancel_i;
      if (accept) begin
        count        <= '0;
        rem_q        <= '0;
        quo_q        <= dividend_mag;
        divisor_q    <= divisor_mag;
        dividend_raw <= dividend_i;
        neg_quo      <= dividend_neg ^ divisor_neg;
        neg_rem      <= dividend_neg;
        div_zero     <= (divisor_i == '0);
        early_q      <= early_take;
      end else if (state == CALC && !cancel_i) begin
        rem_q <= rem_next;
        quo_q <= {quo_q[WIDTH-2:0], quo_bit};
        count <= count + 5'd1;
      end
      if (state == FIX && !cancel_i) result_q <= fix_result;
    end
  end

  assign busy_o   = (state != IDLE);
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed self-checking bench for mdu_div_iter (default and DIV_EARLY_OUT_EN builds).
module tb_mdu_div_iter;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = DIV_EARLY_LATENCY;
`else
  localparam int EARLY_LAT = DIV_LATENCY;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        cancel_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mdu_div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .cancel_i   (cancel_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one divide in the current cycle and wait (bounded) for ready_o.
  // Returns in the cycle where ready_o is high.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input bit scramble,
                         input logic [63:0] exp_res, input int exp_lat);
    int n;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = sgn;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    if (scramble) begin
      dividend_i = $urandom;
      divisor_i  = $urandom_range(1, 100);
      signed_i   = ~sgn;
    end
    check({tag, " busy_after_accept"}, 64'(busy_o), 64'd1);
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " busy_at_ready"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int seen;
    rst        = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    cancel_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    tick();
    tick();
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'h0);
    rst = 1'b1;
    tick();

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 64'h00000002_0000000E, DIV_LATENCY);
    tick();
    check("u100_7 pulse_single", 64'(ready_o), 64'd0);

    run_div("s-7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFD, DIV_LATENCY);
    tick();
    run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h00000000_80000000, DIV_LATENCY);
    tick();
    run_div("u5_0", 32'd5, 32'd0, 1'b0, 1'b0, 64'h00000005_FFFFFFFF, EARLY_LAT);
    tick();

    // Flush in the middle of CALC: no pulse, previous result kept.
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    signed_i   = 1'b0;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("cancel busy", 64'(busy_o), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (ready_o) seen++;
    end
    check("cancel no_ready", 64'(seen), 64'd0);
    check("cancel result_kept", result_o, 64'h00000005_FFFFFFFF);

    // Back-to-back: second start issued in the ready cycle of the first.
    run_div("u20_3", 32'd20, 32'd3, 1'b0, 1'b0, 64'h00000002_00000006, DIV_LATENCY);
    run_div("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 64'h00000001_FFFFFFFD, DIV_LATENCY);
    tick();
    check("s7_-2 pulse_single", 64'(ready_o), 64'd0);

    run_div("s-5_0", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, 64'hFFFFFFFB_FFFFFFFF, EARLY_LAT);
    tick();
    run_div("u1000_7_scr", 32'd1000, 32'd7, 1'b0, 1'b1, 64'h00000006_0000008E, DIV_LATENCY);
    tick();
    run_div("u3_9", 32'd3, 32'd9, 1'b0, 1'b0, 64'h00000003_00000000, EARLY_LAT);
    tick();

    // Cancel and start together in IDLE: nothing is accepted.
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    cancel_i   = 1'b1;
    tick();
    start_i  = 1'b0;
    cancel_i = 1'b0;
    check("start_cancel busy", 64'(busy_o), 64'd0);

    // Reset in the middle of an operation.
    dividend_i = 32'd77;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    rst = 1'b0;
    tick();
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'h0);
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (ready_o) seen++;
    end
    check("midrst no_ready", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
